// File: rtl/vx_vec_lane_sequencer.sv
// Expands dispatched vector operand packets into one execute beat per register lane;
// scalar packets pass through as a single beat. Single output register, 1-cycle latency.
module vx_vec_lane_sequencer #(
  parameter int NUM_LANES = 8,
  parameter int DATAW     = 512,
  parameter int NR_BITS   = 6,
  parameter int LANE_BITS = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1,
  parameter int CNT_BITS  = $clog2(NUM_LANES + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [DATAW-1:0]    in_data,
  input  logic                in_is_vec,
  input  logic [NR_BITS-1:0]  in_rd,
  input  logic [NR_BITS-1:0]  in_vd,
  input  logic [CNT_BITS-1:0] in_num_lanes,
  output logic                in_ready,
  output logic                out_valid,
  output logic [DATAW-1:0]    out_data,
  output logic                out_is_vec,
  output logic [NR_BITS-1:0]  out_rd,
  output logic [NR_BITS-1:0]  out_vd,
  output logic [NR_BITS-1:0]  out_lane_id,
  output logic                out_is_last,
  input  logic                out_ready,
  output logic                busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] LAST  = 2'd2;

  logic [1:0]           state;
  logic [LANE_BITS-1:0] lane;
  logic [LANE_BITS-1:0] lane_next;
  logic [CNT_BITS-1:0]  total;
  logic [CNT_BITS-1:0]  in_total;
  logic [NR_BITS-1:0]   rd_next;
  logic                 last_next;
  logic                 in_fire;
  logic                 out_fire;

  // Handshakes: a transfer happens on a clock edge where valid && ready.
  // in_ready is combinational on out_ready so the final beat and the next
  // packet can overlap in the same cycle without a bubble.
  assign out_valid   = (state != IDLE);
  assign out_is_last = (state == LAST);
  assign in_ready    = !out_valid || (out_ready && out_is_last);
  assign busy        = out_valid && !out_is_last;
  assign in_fire     = in_valid && in_ready;
  assign out_fire    = out_valid && out_ready;
  assign out_lane_id = NR_BITS'(lane);

  // Zero or oversized lane counts are clamped to a legal group size.
  always_comb begin
    in_total = in_num_lanes;
    if (!in_is_vec || (in_num_lanes == '0)) begin
      in_total = CNT_BITS'(1);
    end else if (in_num_lanes > CNT_BITS'(NUM_LANES)) begin
      in_total = CNT_BITS'(NUM_LANES);
    end
  end

  assign lane_next = lane + LANE_BITS'(1);
  assign rd_next   = out_vd + NR_BITS'(lane_next);
  assign last_next = (CNT_BITS'(lane_next) == (total - CNT_BITS'(1)));

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      lane       <= '0;
      total      <= '0;
      out_rd     <= '0;
      out_vd     <= '0;
      out_is_vec <= 1'b0;
    end else if (in_fire) begin
      state      <= (in_total == CNT_BITS'(1)) ? LAST : ISSUE;
      lane       <= '0;
      total      <= in_total;
      out_rd     <= in_is_vec ? in_vd : in_rd;
      out_vd     <= in_vd;
      out_is_vec <= in_is_vec;
    end else if (out_fire) begin
      if (out_is_last) begin
        state <= IDLE;
      end else begin
        lane   <= lane_next;
        out_rd <= rd_next;
        state  <= last_next ? LAST : ISSUE;
      end
    end
  end

  // Payload is never cleared; it only changes when a new packet is taken.
  always_ff @(posedge clk) begin
    if (!reset && in_fire) begin
      out_data <= in_data;
    end
  end

`ifndef SYNTHESIS
  a_data_stable: assert property (@(posedge clk) disable iff (reset)
    (out_valid && !out_ready) |=> $stable(out_data));
  a_lane_range: assert property (@(posedge clk) disable iff (reset)
    (int'(lane) < NUM_LANES));
  a_in_hold: assert property (@(posedge clk) disable iff (reset)
    (in_valid && !in_ready) |=> in_valid);
`endif

endmodule
